shift_seq_ctrl: RTL

- Sequencer for the 4-bit universal shift register (PISO/SIPO, left/right).
- Accepts one transfer command per valid/ready handshake and drives the register's ld/shft_en/mode/dir/pa_in.
- Counts exactly WIDTH shifts, captures the parallel result, and returns it on a valid/ready response channel.
- Sits between the system bus-side logic and the shift register datapath.

---
 rtl/shift_seq_pkg.sv | 18 +
 rtl/shift_seq_pacer.sv | 64 ++++++
 rtl/shift_seq_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared types and constants for the shift register sequencer.
// Optional clock divider: define SHIFT_SEQ_CLKDIV_EN.
package shift_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    CAPT,
    RESP
  } state_e;

  localparam logic MODE_PISO = 1'b0;
  localparam logic MODE_SIPO = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shift_seq_pacer.sv
// shift_seq_pacer: bit counter and shift tick generator for the sequencer.
// Optional divider (div low cycles between ticks) under SHIFT_SEQ_CLKDIV_EN.
module shift_seq_pacer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
`ifdef SHIFT_SEQ_CLKDIV_EN
  ,
  parameter int DIV_W = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             run,
`ifdef SHIFT_SEQ_CLKDIV_EN
  input  logic             accept,
  input  logic [DIV_W-1:0] div,
`endif
  output logic             tick,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

`ifdef SHIFT_SEQ_CLKDIV_EN
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] gap;

  // gap counts the idle cycles left before the next tick
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      gap   <= '0;
    end else begin
      if (accept)
        div_q <= div;
      if (clear)
        gap <= '0;
      else if (tick)
        gap <= div_q;
      else if (gap != '0)
        gap <= gap - 1'b1;
    end
  end

  assign tick = run & (gap == '0);
`else
  assign tick = run;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (tick)
      cnt <= cnt + 1'b1;
  end

  assign last = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: command/response sequencer for the universal shift register.
// Optional divided shift rate: define SHIFT_SEQ_CLKDIV_EN (adds div port).
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
`ifdef SHIFT_SEQ_CLKDIV_EN
  ,
  parameter int DIV_W = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_mode,
  input  logic             cmd_dir,
  input  logic [WIDTH-1:0] cmd_data,
`ifdef SHIFT_SEQ_CLKDIV_EN
  input  logic [DIV_W-1:0] div,
`endif
  output logic             sr_ld,
  output logic             sr_shft_en,
  output logic             sr_mode,
  output logic             sr_dir,
  output logic [WIDTH-1:0] sr_pa_in,
  input  logic [WIDTH-1:0] sr_pa_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  state_e           state;
  state_e           state_nxt;
  logic [WIDTH-1:0] data_q;
  logic             accept;
  logic             tick;
  logic             last;

  assign cmd_ready = (state == IDLE) & ~rst;
  assign accept    = cmd_valid & cmd_ready;
  assign busy      = (state != IDLE);

  shift_seq_pacer #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
`ifdef SHIFT_SEQ_CLKDIV_EN
    ,
    .DIV_W (DIV_W)
`endif
  ) u_pacer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == LOAD),
    .run    (state == SHIFT),
`ifdef SHIFT_SEQ_CLKDIV_EN
    .accept (accept),
    .div    (div),
`endif
    .tick   (tick),
    .last   (last)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // mode/dir stay on the register pins until the next acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_mode  <= MODE_PISO;
      sr_dir   <= DIR_RIGHT;
      data_q   <= '0;
      rsp_data <= '0;
    end else begin
      if (accept) begin
        sr_mode <= cmd_mode;
        sr_dir  <= cmd_dir;
        data_q  <= cmd_data;
      end
      if (state == CAPT)
        rsp_data <= (sr_mode == MODE_SIPO) ? sr_pa_out : '0;
    end
  end

  always_comb begin
    state_nxt  = state;
    sr_ld      = 1'b0;
    sr_shft_en = 1'b0;
    sr_pa_in   = '0;
    rsp_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept)
          state_nxt = LOAD;
      end
      LOAD: begin
        sr_ld     = 1'b1;
        sr_pa_in  = (sr_mode == MODE_PISO) ? data_q : '0;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        sr_shft_en = tick;
        if (tick && last)
          state_nxt = CAPT;
      end
      CAPT: begin
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready)
          state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
